// File: rtl/qam_tx_frame_ctrl_if.sv
// Host/datapath bundle for the 16-QAM transmit frame sequencer.
// The host uses the master modport and the sequencer uses the slave modport.
interface qam_tx_frame_ctrl_if #(
  parameter int LEN_W = 10
);
  logic             tx_req;
  logic [LEN_W-1:0] tx_len;
  logic             tx_abort;
  logic             tx_ack;
  logic             busy;
  logic             gen_enable;
  logic             lo_start;
  logic             preamble_sel;
  logic             sym_strobe;
  logic [LEN_W-1:0] sym_count;
  logic             tx_done;
  logic             err_zero_len;

  modport master (
    output tx_req, tx_len, tx_abort,
    input  tx_ack, busy, gen_enable, lo_start, preamble_sel,
    input  sym_strobe, sym_count, tx_done, err_zero_len
  );

  modport slave (
    input  tx_req, tx_len, tx_abort,
    output tx_ack, busy, gen_enable, lo_start, preamble_sel,
    output sym_strobe, sym_count, tx_done, err_zero_len
  );
endinterface

// File: rtl/qam_tx_frame_ctrl.sv
// Frame sequencer for the 16-QAM transmit chain: WARMUP, PREAMBLE, PAYLOAD, GUARD, DONE on symbol boundaries.
// Optional macro QAM_TX_FRAME_CTRL_BACK2BACK_EN chains a new request from DONE straight into PREAMBLE.
module qam_tx_frame_ctrl #(
  parameter int SYM_CYCLES    = 4,
  parameter int PREAMBLE_SYMS = 8,
  parameter int GUARD_SYMS    = 4,
  parameter int LEN_W         = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  qam_tx_frame_ctrl_if.slave    bus
);
  localparam int PH_W = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SYM_CYCLES - 1);
  localparam logic [LEN_W-1:0] PRE_LAST = LEN_W'(PREAMBLE_SYMS - 1);
  localparam logic [LEN_W-1:0] GRD_LAST = LEN_W'(GUARD_SYMS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    PREAMBLE,
    PAYLOAD,
    GUARD,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [PH_W-1:0]  phase_reg, phase_next;
  logic [LEN_W-1:0] seg_reg, seg_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] count_reg, count_next;
  logic [LEN_W-1:0] count_inc;
  logic             sym_end;
  logic             ack_next;
  logic             err_next;
  logic             lo_hold;

  logic tx_ack_reg;
  logic busy_reg;
  logic gen_enable_reg;
  logic lo_start_reg;
  logic preamble_sel_reg;
  logic sym_strobe_reg;
  logic tx_done_reg;
  logic err_zero_len_reg;

  assign sym_end   = (phase_reg == PH_LAST);
  assign count_inc = count_reg + 1'b1;

`ifdef QAM_TX_FRAME_CTRL_BACK2BACK_EN
  // Keep the oscillator running through DONE when a follow-on frame is already pending.
  assign lo_hold = bus.tx_req && (bus.tx_len != '0);
`else
  assign lo_hold = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    phase_next = sym_end ? '0 : phase_reg + 1'b1;
    seg_next   = seg_reg;
    len_next   = len_reg;
    count_next = count_reg;
    ack_next   = 1'b0;
    err_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.tx_req) begin
          if (bus.tx_len != '0) begin
            state_next = WARMUP;
            len_next   = bus.tx_len;
            count_next = '0;
            ack_next   = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      WARMUP: begin
        if (bus.tx_abort) begin
          state_next = GUARD;
        end else if (sym_end) begin
          state_next = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (bus.tx_abort) begin
          state_next = GUARD;
        end else if (sym_end) begin
          if (seg_reg == PRE_LAST) begin
            state_next = PAYLOAD;
          end else begin
            seg_next = seg_reg + 1'b1;
          end
        end
      end
      PAYLOAD: begin
        // A symbol finishing together with an abort still counts as completed.
        if (sym_end) begin
          count_next = count_inc;
          if (count_inc == len_reg) begin
            state_next = GUARD;
          end
        end
        if (bus.tx_abort) begin
          state_next = GUARD;
        end
      end
      GUARD: begin
        if (sym_end) begin
          if (seg_reg == GRD_LAST) begin
            state_next = DONE;
          end else begin
            seg_next = seg_reg + 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
`ifdef QAM_TX_FRAME_CTRL_BACK2BACK_EN
        if (bus.tx_req) begin
          if (bus.tx_len != '0) begin
            state_next = PREAMBLE;
            len_next   = bus.tx_len;
            count_next = '0;
            ack_next   = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Every state entry starts a fresh symbol and a fresh segment count.
    if (state_next != state_reg || state_reg == IDLE) begin
      phase_next = '0;
      seg_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      phase_reg        <= '0;
      seg_reg          <= '0;
      len_reg          <= '0;
      count_reg        <= '0;
      tx_ack_reg       <= 1'b0;
      busy_reg         <= 1'b0;
      gen_enable_reg   <= 1'b0;
      lo_start_reg     <= 1'b0;
      preamble_sel_reg <= 1'b0;
      sym_strobe_reg   <= 1'b0;
      tx_done_reg      <= 1'b0;
      err_zero_len_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      phase_reg        <= phase_next;
      seg_reg          <= seg_next;
      len_reg          <= len_next;
      count_reg        <= count_next;
      tx_ack_reg       <= ack_next;
      err_zero_len_reg <= err_next;
      // Outputs are decoded from the next state so they line up with the registered state.
      busy_reg         <= (state_next != IDLE);
      gen_enable_reg   <= (state_next == PAYLOAD);
      preamble_sel_reg <= (state_next == PREAMBLE);
      lo_start_reg     <= (state_next inside {WARMUP, PREAMBLE, PAYLOAD, GUARD}) ||
                          ((state_next == DONE) && lo_hold);
      sym_strobe_reg   <= (state_next inside {PREAMBLE, PAYLOAD, GUARD}) &&
                          (phase_next == PH_LAST);
      tx_done_reg      <= (state_next == DONE);
    end
  end

  assign bus.tx_ack       = tx_ack_reg;
  assign bus.busy         = busy_reg;
  assign bus.gen_enable   = gen_enable_reg;
  assign bus.lo_start     = lo_start_reg;
  assign bus.preamble_sel = preamble_sel_reg;
  assign bus.sym_strobe   = sym_strobe_reg;
  assign bus.sym_count    = count_reg;
  assign bus.tx_done      = tx_done_reg;
  assign bus.err_zero_len = err_zero_len_reg;
endmodule

// File: tb/tb_qam_tx_frame_ctrl.sv
// Directed bench for qam_tx_frame_ctrl with default parameters.
// Cycle 0 is the cycle in which tx_req is driven; outputs are read 1 ns after each rising edge.
module tb_qam_tx_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  qam_tx_frame_ctrl_if #(.LEN_W(10)) bus ();

  qam_tx_frame_ctrl #(
    .SYM_CYCLES(4), .PREAMBLE_SYMS(8), .GUARD_SYMS(4), .LEN_W(10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {tx_ack, busy, gen_enable, lo_start, preamble_sel, tx_done, sym_strobe, err_zero_len}
  function automatic logic [7:0] obs_vec();
    return {bus.tx_ack, bus.busy, bus.gen_enable, bus.lo_start,
            bus.preamble_sel, bus.tx_done, bus.sym_strobe, bus.err_zero_len};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.tx_req = 1'b1; bus.tx_len = 10'd5; bus.tx_abort = 1'b0;
    step(); step(); step();
    checks++;
    if (obs_vec() !== 8'b0 || bus.sym_count !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b cnt=%0d want=00000000 cnt=0", obs_vec(), bus.sym_count);
    end
    bus.tx_req = 1'b0; bus.tx_len = 10'd0;
    rst = 1'b0;
    step();
    $display("reset: outputs=%b sym_count=%0d", obs_vec(), bus.sym_count);
  endtask

  task automatic test_frame();
    logic [7:0] exp;
    int         strobes = 0;
    int         exp_cnt;
    step();
    bus.tx_req = 1'b1; bus.tx_len = 10'd16;
    for (int c = 1; c <= 120; c++) begin
      step();
      exp = {c == 1, c >= 1 && c <= 117, c >= 37 && c <= 100, c >= 1 && c <= 116,
             c >= 5 && c <= 36, c == 117, c >= 5 && c <= 116 && (c % 4) == 0, 1'b0};
      checks++;
      if (obs_vec() !== exp) begin
        errors++;
        $display("FAIL frame_outputs cycle=%0d got=%b want=%b", c, obs_vec(), exp);
      end
      exp_cnt = (c <= 37) ? 0 : (c - 37) / 4;
      if (exp_cnt > 16) exp_cnt = 16;
      checks++;
      if (bus.sym_count !== 10'(exp_cnt)) begin
        errors++;
        $display("FAIL frame_sym_count cycle=%0d got=%0d want=%0d", c, bus.sym_count, exp_cnt);
      end
      if (bus.sym_strobe) strobes++;
      if (c == 1) begin
        bus.tx_req = 1'b0;
        bus.tx_len = 10'd3;
      end
    end
    checks++;
    if (strobes != 28) begin
      errors++;
      $display("FAIL frame_strobes got=%0d want=28", strobes);
    end
    $display("frame len=16: strobes=%0d sym_count=%0d", strobes, bus.sym_count);
  endtask

  task automatic test_zero_len();
    step();
    bus.tx_req = 1'b1; bus.tx_len = 10'd0;
    step();
    bus.tx_req = 1'b0;
    checks++;
    if (obs_vec() !== 8'b00000001) begin
      errors++;
      $display("FAIL zero_len_c1 got=%b want=00000001", obs_vec());
    end
    step();
    checks++;
    if (obs_vec() !== 8'b00000000) begin
      errors++;
      $display("FAIL zero_len_c2 got=%b want=00000000", obs_vec());
    end
    $display("zero_len: outputs after pulse=%b", obs_vec());
  endtask

  task automatic test_abort();
    int done_cyc = -1;
    int guard_strobes = 0;
    step();
    bus.tx_req = 1'b1; bus.tx_len = 10'd20;
    for (int c = 1; c <= 80; c++) begin
      step();
      if (c == 59) begin
        checks++;
        if (bus.gen_enable !== 1'b1) begin
          errors++;
          $display("FAIL abort_gen_before got=%b want=1", bus.gen_enable);
        end
      end
      if (c == 60) begin
        checks++;
        if (bus.gen_enable !== 1'b0 || bus.lo_start !== 1'b1) begin
          errors++;
          $display("FAIL abort_gen_after got gen=%b lo=%b want gen=0 lo=1", bus.gen_enable, bus.lo_start);
        end
      end
      if (c == 77) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL abort_busy_end got=%b want=0", bus.busy);
        end
      end
      if (bus.tx_done && done_cyc < 0) done_cyc = c;
      if (c >= 60 && bus.sym_strobe) guard_strobes++;
      if (c == 1)  bus.tx_req = 1'b0;
      if (c == 59) bus.tx_abort = 1'b1;
      if (c == 60) bus.tx_abort = 1'b0;
    end
    checks++;
    if (done_cyc != 76) begin
      errors++;
      $display("FAIL abort_done_cycle got=%0d want=76", done_cyc);
    end
    checks++;
    if (guard_strobes != 4) begin
      errors++;
      $display("FAIL abort_guard_strobes got=%0d want=4", guard_strobes);
    end
    checks++;
    if (bus.sym_count !== 10'd5) begin
      errors++;
      $display("FAIL abort_sym_count got=%0d want=5", bus.sym_count);
    end
    $display("abort: done_cycle=%0d guard_strobes=%0d sym_count=%0d", done_cyc, guard_strobes, bus.sym_count);
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int busys = 0;
    step();
    bus.tx_req = 1'b1; bus.tx_len = 10'd16;
    for (int c = 1; c <= 50; c++) begin
      step();
      if (c == 1) bus.tx_req = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (obs_vec() !== 8'b0 || bus.sym_count !== 10'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs got=%b cnt=%0d want=00000000 cnt=0", obs_vec(), bus.sym_count);
    end
    for (int c = 0; c < 150; c++) begin
      step();
      if (bus.tx_done) dones++;
      if (bus.busy) busys++;
    end
    checks++;
    if (dones != 0 || busys != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet got dones=%0d busy_cycles=%0d want 0 and 0", dones, busys);
    end
    $display("reset_mid: tx_done after reset=%0d busy cycles=%0d", dones, busys);
  endtask

  task automatic test_max_len();
    int done_cyc = -1;
    int strobes = 0;
    int pay_strobes = 0;
    step();
    bus.tx_req = 1'b1; bus.tx_len = 10'd1023;
    for (int c = 1; c <= 4200; c++) begin
      step();
      if (bus.sym_strobe) strobes++;
      if (bus.sym_strobe && bus.gen_enable) pay_strobes++;
      if (bus.tx_done && done_cyc < 0) done_cyc = c;
      if (c == 1) bus.tx_req = 1'b0;
    end
    checks++;
    if (pay_strobes != 1023) begin
      errors++;
      $display("FAIL max_payload_strobes got=%0d want=1023", pay_strobes);
    end
    checks++;
    if (strobes != 1035) begin
      errors++;
      $display("FAIL max_total_strobes got=%0d want=1035", strobes);
    end
    checks++;
    if (done_cyc != 4145) begin
      errors++;
      $display("FAIL max_done_cycle got=%0d want=4145", done_cyc);
    end
    checks++;
    if (bus.sym_count !== 10'd1023) begin
      errors++;
      $display("FAIL max_sym_count got=%0d want=1023", bus.sym_count);
    end
    $display("max_len: done_cycle=%0d payload_strobes=%0d sym_count=%0d", done_cyc, pay_strobes, bus.sym_count);
  endtask

  task automatic test_back_to_back();
    int done_cyc = -1;
    int ack2_cyc = -1;
    int acks = 0;
    logic busy62 = 1'bx, lo61 = 1'bx, lo62 = 1'bx, lo63 = 1'bx;
    logic pre62 = 1'bx, pre63 = 1'bx, pre67 = 1'bx;
    step();
    bus.tx_req = 1'b1; bus.tx_len = 10'd2;
    for (int c = 1; c <= 75; c++) begin
      step();
      if (bus.tx_ack) begin
        acks++;
        if (acks == 2) ack2_cyc = c;
      end
      if (bus.tx_done && done_cyc < 0) done_cyc = c;
      if (c == 61) lo61 = bus.lo_start;
      if (c == 62) begin busy62 = bus.busy; lo62 = bus.lo_start; pre62 = bus.preamble_sel; end
      if (c == 63) begin lo63 = bus.lo_start; pre63 = bus.preamble_sel; end
      if (c == 67) pre67 = bus.preamble_sel;
    end
    bus.tx_req = 1'b0;
    checks++;
    if (done_cyc != 61) begin
      errors++;
      $display("FAIL b2b_first_done got=%0d want=61", done_cyc);
    end
`ifdef QAM_TX_FRAME_CTRL_BACK2BACK_EN
    checks++;
    if (ack2_cyc != 62 || busy62 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ack got ack2=%0d busy62=%b want ack2=62 busy62=1", ack2_cyc, busy62);
    end
    checks++;
    if (lo61 !== 1'b1 || lo62 !== 1'b1 || pre62 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_chain got lo61=%b lo62=%b pre62=%b want 1 1 1", lo61, lo62, pre62);
    end
`else
    checks++;
    if (ack2_cyc != 63 || busy62 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ack got ack2=%0d busy62=%b want ack2=63 busy62=0", ack2_cyc, busy62);
    end
    checks++;
    if (lo61 !== 1'b0 || lo62 !== 1'b0 || lo63 !== 1'b1 || pre63 !== 1'b0 || pre67 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_warmup got lo61=%b lo62=%b lo63=%b pre63=%b pre67=%b want 0 0 1 0 1",
               lo61, lo62, lo63, pre63, pre67);
    end
`endif
    for (int c = 0; c < 150; c++) step();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got busy=%b want=0", bus.busy);
    end
    $display("back_to_back: first_done=%0d second_ack=%0d busy62=%b", done_cyc, ack2_cyc, busy62);
  endtask

  initial begin
    bus.tx_req = 1'b0; bus.tx_len = '0; bus.tx_abort = 1'b0;
    test_reset();
    test_frame();
    test_zero_len();
    test_abort();
    test_reset_mid();
    test_max_len();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/qam_tx_frame_ctrl.md
Name: qam_tx_frame_ctrl

Overview:
- Frame sequencer for the 16-QAM transmit chain.
- Accepts a host frame request and drives the enables of the data generator, serial-to-parallel stage, local oscillator and modulator.
- Sequences each frame as warm-up, preamble, payload, guard, done, all on 4-bit symbol boundaries.
- Sits between the host/test logic and the transmit datapath; replaces the single shared start line.

Parameters:
- SYM_CYCLES, 4: clocks per symbol (one serial bit per clock, 4 bits per 16-QAM symbol); must be at least 2.
- PREAMBLE_SYMS, 8: number of preamble symbols per frame.
- GUARD_SYMS, 4: number of guard symbols after the payload, with the carrier on and data off.
- LEN_W, 10: width of the payload length and symbol counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- tx_req  in  1  frame request; sampled only in IDLE.
- tx_len  in  LEN_W  payload symbol count; captured when tx_req is sampled.
- tx_abort  in  1  terminate the current frame early.
- tx_ack  out  1  one-cycle pulse: request accepted.
- busy  out  1  high from acceptance through the DONE cycle.
- gen_enable  out  1  enable for the data generator and serial-to-parallel stage.
- lo_start  out  1  start for the local oscillator and modulator.
- preamble_sel  out  1  high during PREAMBLE; the modulator substitutes a fixed preamble symbol.
- sym_strobe  out  1  pulse on the last cycle of each symbol in PREAMBLE, PAYLOAD and GUARD.
- sym_count  out  LEN_W  payload symbols completed in the current or last frame.
- tx_done  out  1  one-cycle pulse at frame end.
- err_zero_len  out  1  one-cycle pulse: request rejected because tx_len == 0.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - All outputs are registered.
  - On rst (synchronous, active-high): state = IDLE, phase and symbol counters = 0, every output = 0.
  - rst mid-frame aborts immediately, with no guard and no tx_done.
- States: IDLE, WARMUP, PREAMBLE, PAYLOAD, GUARD, DONE.
- Phase counter:
  - Counts 0..SYM_CYCLES-1 in WARMUP, PREAMBLE, PAYLOAD and GUARD.
  - Cleared on every state entry.
  - A symbol ends when phase == SYM_CYCLES-1.
- IDLE:
  - tx_req=1 and tx_len!=0: capture tx_len, clear sym_count, go to WARMUP. tx_ack and busy rise the next cycle.
  - tx_req=1 and tx_len==0: err_zero_len pulses next cycle; stay in IDLE.
  - tx_abort is ignored in IDLE.
- WARMUP: lo_start=1 for one symbol (SYM_CYCLES cycles) so the oscillator runs before data; then go to PREAMBLE.
- PREAMBLE:
  - lo_start=1, preamble_sel=1, gen_enable=0.
  - Lasts PREAMBLE_SYMS symbols, then go to PAYLOAD.
- PAYLOAD:
  - lo_start=1, gen_enable=1.
  - sym_count increments on each sym_strobe.
  - After the captured-length number of symbols, go to GUARD.
- GUARD:
  - lo_start=1, gen_enable=0.
  - Lasts GUARD_SYMS symbols, then go to DONE.
- DONE:
  - tx_done=1 for one cycle, lo_start=0, busy=1.
  - Next state is IDLE, or PREAMBLE when the optional feature applies.
- Outputs follow the state registered, i.e. they change the cycle after the state transition edge.
- Timing: frame length from acceptance to tx_done = SYM_CYCLES*(1+PREAMBLE_SYMS+len+GUARD_SYMS)+1 cycles.
- Abort:
  - tx_abort=1 in WARMUP, PREAMBLE or PAYLOAD forces GUARD with phase cleared.
  - gen_enable drops the next cycle.
  - sym_count freezes at the completed-symbol count.
  - Abort in GUARD or DONE is ignored.
- Abort and end of payload in the same cycle: treated as a normal completion, with sym_count = len.
- tx_req while busy is ignored; no ack and no error.
- tx_len changes after capture have no effect.
- Counter sizing: the payload counter compares against the captured length at full LEN_W width, so len = 2^LEN_W-1 must complete without wrap.

Optional Feature:
- Macro: QAM_TX_FRAME_CTRL_BACK2BACK_EN.
- When defined, in DONE:
  - if tx_req=1 and tx_len!=0, capture tx_len and go directly to PREAMBLE.
  - tx_ack pulses; busy stays high; lo_start stays high (the oscillator is not restarted); WARMUP is skipped.
  - If tx_len==0 in DONE, pulse err_zero_len and go to IDLE.
- When undefined: DONE always goes to IDLE, and tx_req in DONE is ignored.

Test Plan:
- Frame completion: defaults, tx_len=16, tx_req pulsed at cycle 0.
  - tx_ack at cycle 1.
  - lo_start high cycles 1-116; preamble_sel high cycles 5-36; gen_enable high cycles 37-100.
  - 28 sym_strobe pulses total (8 preamble + 16 payload + 4 guard).
  - tx_done at cycle 117; sym_count=16; busy low at cycle 118.
- Zero length: tx_len=0 with tx_req -> err_zero_len pulses once at cycle 1; tx_ack, busy and lo_start stay 0.
- Abort: tx_len=20, tx_abort asserted on the 3rd cycle of payload symbol 6.
  - gen_enable falls the next cycle.
  - GUARD lasts exactly 16 cycles, then tx_done.
  - sym_count=5.
- Reset mid-PAYLOAD: rst held 1 cycle -> next cycle all outputs 0 and state IDLE; no tx_done ever for that frame.
- Max length: LEN_W=10, tx_len=1023 -> exactly 1023 payload strobes, sym_count=1023, tx_done at cycle 4*(1+8+1023+4)+1=4145.
- Back-to-back: tx_req held high through the first frame.
  - Without the macro: the second tx_ack comes one cycle after busy falls, and WARMUP is repeated.
  - With the macro: tx_ack coincides with the cycle after tx_done, lo_start never drops, and preamble_sel rises the next cycle.
